// File: rtl/ptr_alloc_arb.sv
// Free-list pointer allocator: hands out node pointers to two requesters under
// round-robin arbitration and takes back one freed pointer per cycle.
module ptr_alloc_arb #(
    parameter int unsigned N_PTR = 16,
    parameter int unsigned PTR_W = $clog2(N_PTR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       alloc_req,
    output logic [1:0]       alloc_gnt,
    output logic             alloc_vld,
    output logic             alloc_id,
    output logic [PTR_W-1:0] alloc_ptr,
    input  logic             free_vld,
    input  logic [PTR_W-1:0] free_ptr,
    output logic             ready,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   init_idx_q, init_idx_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               rr_last_q, rr_last_d;
    logic               ready_q, ready_d;
    logic               alloc_vld_q, alloc_vld_d;
    logic               alloc_id_q, alloc_id_d;
    logic [PTR_W-1:0]   alloc_ptr_q, alloc_ptr_d;

    logic [PTR_W-1:0]   next_q [N_PTR];
    logic               nxt_we;
    logic [PTR_W-1:0]   nxt_waddr;
    logic [PTR_W-1:0]   nxt_wdata;

    logic [1:0]         gnt_c;
    logic               gnt_any;
    logic               free_acc;

    // Round-robin: on conflict the requester that did not win last time goes.
    always_comb begin
        gnt_c = 2'b00;
        if (ready_q && (count_q != '0)) begin
            case (alloc_req)
                2'b01:   gnt_c = 2'b01;
                2'b10:   gnt_c = 2'b10;
                2'b11:   gnt_c = rr_last_q ? 2'b01 : 2'b10;
                default: gnt_c = 2'b00;
            endcase
        end
    end

    assign gnt_any  = |gnt_c;
    assign free_acc = ready_q & free_vld;

    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        rr_last_d   = rr_last_q;
        ready_d     = (state_q == ST_RUN);
        alloc_vld_d = gnt_any;
        alloc_id_d  = alloc_id_q;
        alloc_ptr_d = alloc_ptr_q;
        nxt_we      = 1'b0;
        nxt_waddr   = tail_q;
        nxt_wdata   = free_ptr;

        case (state_q)
            ST_INIT: begin
                // Chain the pool 0 -> 1 -> ... -> N_PTR-1, one link per cycle.
                nxt_we     = 1'b1;
                nxt_waddr  = init_idx_q;
                nxt_wdata  = PTR_W'(init_idx_q + PTR_W'(1));
                init_idx_d = PTR_W'(init_idx_q + PTR_W'(1));
                if (init_idx_q == PTR_W'(N_PTR - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (gnt_any) begin
                    rr_last_d   = gnt_c[1];
                    alloc_ptr_d = head_q;
                    alloc_id_d  = gnt_c[1];
                    head_d      = next_q[head_q];
                end
                if (free_acc) begin
                    nxt_we = 1'b1;
                    tail_d = free_ptr;
                    // Pool would be empty after this allocation: freed pointer is the new head.
                    if (count_q == CNT_W'(gnt_any)) begin
                        head_d = free_ptr;
                    end
                end
                case ({free_acc, gnt_any})
                    2'b10:   count_d = CNT_W'(count_q + CNT_W'(1));
                    2'b01:   count_d = CNT_W'(count_q - CNT_W'(1));
                    default: count_d = count_q;
                endcase
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_idx_q  <= '0;
            head_q      <= '0;
            tail_q      <= PTR_W'(N_PTR - 1);
            count_q     <= CNT_W'(N_PTR);
            rr_last_q   <= 1'b1;
            ready_q     <= 1'b0;
            alloc_vld_q <= 1'b0;
            alloc_id_q  <= 1'b0;
            alloc_ptr_q <= '0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            rr_last_q   <= rr_last_d;
            ready_q     <= ready_d;
            alloc_vld_q <= alloc_vld_d;
            alloc_id_q  <= alloc_id_d;
            alloc_ptr_q <= alloc_ptr_d;
        end
    end

    // Next-pointer storage; contents are rebuilt in INIT so it needs no reset.
    always_ff @(posedge clk) begin
        if (nxt_we) begin
            next_q[nxt_waddr] <= nxt_wdata;
        end
    end

    assign alloc_gnt = gnt_c;
    assign alloc_vld = alloc_vld_q;
    assign alloc_id  = alloc_id_q;
    assign alloc_ptr = alloc_ptr_q;
    assign ready     = ready_q;
    assign count     = count_q;
    assign empty     = (count_q == '0);

endmodule

// File: tb/tb_ptr_alloc_arb.sv
// Scoreboard bench for ptr_alloc_arb: a FIFO-of-pointers pool model predicts
// grants and allocated pointers; a monitor checks every alloc_vld beat.
module tb_ptr_alloc_arb;

    localparam int unsigned N_PTR = 16;
    localparam int unsigned PTR_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       alloc_req;
    logic [1:0]       alloc_gnt;
    logic             alloc_vld;
    logic             alloc_id;
    logic [PTR_W-1:0] alloc_ptr;
    logic             free_vld;
    logic [PTR_W-1:0] free_ptr;
    logic             ready;
    logic             empty;
    logic [PTR_W:0]   count;

    int total = 0;
    int bad   = 0;

    int pool[$];
    int outst[$];
    int sb_id[$];
    int sb_ptr[$];
    int last_w;

    always #5 clk = ~clk;

    ptr_alloc_arb #(.N_PTR(N_PTR), .PTR_W(PTR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .alloc_req (alloc_req),
        .alloc_gnt (alloc_gnt),
        .alloc_vld (alloc_vld),
        .alloc_id  (alloc_id),
        .alloc_ptr (alloc_ptr),
        .free_vld  (free_vld),
        .free_ptr  (free_ptr),
        .ready     (ready),
        .empty     (empty),
        .count     (count)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented allocation must match the oldest expected one.
    always @(posedge clk) begin
        #1;
        if (alloc_vld === 1'b1) begin
            if (sb_ptr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_alloc: got ptr %0d expected no allocation at %0t", alloc_ptr, $time);
            end else begin
                chk("alloc_id", int'(alloc_id), sb_id.pop_front());
                chk("alloc_ptr", int'(alloc_ptr), sb_ptr.pop_front());
            end
        end
    end

    task automatic model_reset();
        pool.delete();
        for (int i = 0; i < N_PTR; i++) pool.push_back(i);
        outst.delete();
        sb_id.delete();
        sb_ptr.delete();
        last_w = 1;
    endtask

    // Reset, then watch INIT: no grants and not ready for 16 edges, ready on the 17th.
    task automatic do_reset();
        rst       = 1'b1;
        alloc_req = 2'b11;
        free_vld  = 1'b0;
        free_ptr  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= N_PTR; k++) begin
            @(negedge clk);
            chk("init_ready", int'(ready), 0);
            chk("init_gnt", int'(alloc_gnt), 0);
            chk("init_count", int'(count), N_PTR);
            chk("init_empty", int'(empty), 0);
        end
        @(negedge clk);
        chk("ready_up", int'(ready), 1);
        alloc_req = 2'b00;
    endtask

    // One cycle: drive, predict from the pool model, queue expected allocation.
    task automatic do_cycle(input logic [1:0] req, input bit fv, input int fp);
        int w;
        int p;
        logic [1:0] eg;
        alloc_req = req;
        free_vld  = fv;
        free_ptr  = PTR_W'(fp);
        #1;
        chk("count", int'(count), pool.size());
        chk("empty", int'(empty), int'(pool.size() == 0));
        w = -1;
        if (pool.size() > 0) begin
            if (req == 2'b01)      w = 0;
            else if (req == 2'b10) w = 1;
            else if (req == 2'b11) w = (last_w == 0) ? 1 : 0;
        end
        eg = (w >= 0) ? 2'(1 << w) : 2'b00;
        chk("alloc_gnt", int'(alloc_gnt), int'(eg));
        if (fv) begin
            for (int i = 0; i < outst.size(); i++) begin
                if (outst[i] == fp) begin
                    outst.delete(i);
                    break;
                end
            end
        end
        if (w >= 0) begin
            last_w = w;
            p = pool.pop_front();
            outst.push_back(p);
            sb_id.push_back(w);
            sb_ptr.push_back(p);
        end
        if (fv) pool.push_back(fp);
        @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit   fv;
        int   fp;
        logic [1:0] rq;

        rst       = 1'b1;
        alloc_req = 2'b00;
        free_vld  = 1'b0;
        free_ptr  = '0;

        // Single requester streams pointers 0,1,2.
        do_reset();
        repeat (3) do_cycle(2'b01, 1'b0, 0);
        do_cycle(2'b00, 1'b0, 0);
        chk("count_after3", int'(count), 13);

        // Both requesting: alternate starting with requester 0.
        do_reset();
        repeat (4) do_cycle(2'b11, 1'b0, 0);
        do_cycle(2'b00, 1'b0, 0);

        // Drain, hold requests on empty pool, free 5 with no grant, then reallocate it.
        do_reset();
        repeat (N_PTR) do_cycle(2'b01, 1'b0, 0);
        repeat (3) do_cycle(2'b11, 1'b0, 0);
        do_cycle(2'b11, 1'b1, 5);
        do_cycle(2'b10, 1'b0, 0);
        do_cycle(2'b00, 1'b0, 0);
        chk("empty_after_realloc", int'(empty), 1);

        // count == 1 with head 9: grant and free 7 together, then get 7.
        do_reset();
        repeat (N_PTR) do_cycle(2'b01, 1'b0, 0);
        do_cycle(2'b00, 1'b1, 9);
        do_cycle(2'b01, 1'b1, 7);
        do_cycle(2'b01, 1'b0, 0);
        do_cycle(2'b00, 1'b0, 0);

        // Reset pulsed while an allocation is being presented.
        do_reset();
        repeat (6) do_cycle(2'b01, 1'b0, 0);
        chk("vld_before_rst", int'(alloc_vld), 1);
        chk("count_before_rst", int'(count), 10);
        rst = 1'b1;
        #1;
        chk("rst_vld", int'(alloc_vld), 0);
        chk("rst_ready", int'(ready), 0);
        chk("rst_count", int'(count), N_PTR);
        do_reset();
        do_cycle(2'b01, 1'b0, 0);
        do_cycle(2'b00, 1'b0, 0);

        // Random traffic: random requests, frees drawn from outstanding pointers.
        for (int n = 0; n < 3000; n++) begin
            rq = 2'($urandom_range(3, 0));
            fv = 1'b0;
            fp = 0;
            if (outst.size() > 0 && $urandom_range(1, 0) == 1) begin
                fv = 1'b1;
                fp = outst[$urandom_range(outst.size() - 1, 0)];
            end
            do_cycle(rq, fv, fp);
        end
        do_cycle(2'b00, 1'b0, 0);
        @(negedge clk);
        chk("sb_drained", sb_ptr.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ptr_alloc_arb.md
# ptr_alloc_arb

Pointer allocator and arbiter for the linked-list node pool. Holds the free list of node pointers as an internal linked list (next-pointer array, head, tail, count). It shares that pool between two allocation requesters under round-robin arbitration and accepts one freed pointer per cycle. Sits between the pointer-request generators and the list storage, and is the only block that hands out node pointers.

## Interface
- N_PTR, 16: number of nodes in the pool; power of two, ≥ 2.
- PTR_W, $clog2(N_PTR): pointer width (the codebase `Pointer` type when N_PTR = 16).
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, asynchronous, active-high.
- alloc_req  in  2  per-requester allocation request, level; held until granted.
- alloc_gnt  out  2  one-hot grant, combinational from alloc_req, state, count, arbitration pointer.
- alloc_vld  out  1  registered; allocated pointer valid.
- alloc_id  out  1  registered; requester index of the allocation on alloc_ptr.
- alloc_ptr  out  PTR_W  registered; allocated pointer.
- free_vld  in  1  return a pointer to the pool this cycle.
- free_ptr  in  PTR_W  pointer being returned.
- ready  out  1  registered; pool initialised, grants and frees accepted.
- empty  out  1  combinational; count == 0.
- count  out  PTR_W+1  registered; free pointers in pool, 0..N_PTR.

## Operation
- States: INIT, RUN.
- On reset: state = INIT, init index i = 0, head = 0, tail = N_PTR-1, count = N_PTR, rr_last = 1 (requester 0 wins first conflict).
- On reset: ready = 0, alloc_vld = 0, alloc_id = 0, alloc_ptr = 0, alloc_gnt = 0.
- INIT: one entry per cycle, next[i] = i+1 (next[N_PTR-1] = 0, don't-care). i increments.
- INIT: after writing i = N_PTR-1, go to RUN; ready = 1 from the following cycle.
- INIT: alloc_gnt = 0 and free_vld is ignored.
- RUN arbitration, when count > 0:
  - Only one request active: that requester is granted.
  - Both requests active: the requester ≠ rr_last is granted.
  - rr_last updates to the granted index.
- RUN, count == 0: no grant, rr_last unchanged.
- Grant effects at the clock edge:
  - alloc_ptr ← head; alloc_id ← granted index; alloc_vld ← 1.
  - head ← next[head]; count decrements.
- No grant: alloc_vld ← 0. alloc_ptr and alloc_id hold.
- Free, RUN only:
  - next[tail] ← free_ptr; tail ← free_ptr; count increments.
  - If the pool is empty after this cycle's allocation, head ← free_ptr as well.
- Simultaneous grant and free:
  - count unchanged.
  - Granted pointer is the pre-edge head.
  - If count == 1, head ← free_ptr and tail ← free_ptr.
- Free with count == 0: the free is accepted and there is no grant the same cycle. head = tail = free_ptr, count = 1.
- Free with count == N_PTR: illegal (double free), behaviour undefined; not checked.
- Freed pointer value is not validated; caller guarantees uniqueness.
- Next-pointer array: N_PTR × PTR_W registers, asynchronous read of next[head].

## Timing
- Allocation latency: request sampled at edge k with grant → alloc_vld/alloc_ptr valid after edge k, for one cycle per grant.
- Throughput: one allocation and one free per cycle, sustained.
- Requester holding alloc_req for M cycles with the other idle and pool non-empty gets M consecutive pointers.
- A freed pointer is allocatable from the cycle after free_vld.
- ready rises N_PTR cycles after rst deasserts, plus the RUN-entry register cycle.
- Async reset mid-operation: all outputs return to reset values immediately; INIT reruns; in-flight alloc_vld is dropped.

## Test plan
- Reset release, N_PTR = 16 → ready low for 16 edges, then high; count = 16; empty = 0; no alloc_gnt while ready = 0 even with alloc_req = 2'b11.
- alloc_req = 2'b01 for 3 cycles after ready → alloc_ptr 0, 1, 2 with alloc_id 0, alloc_vld on three consecutive cycles; count = 13.
- Fresh reset, alloc_req = 2'b11 for 4 cycles → grants 01, 10, 01, 10; alloc_id 0, 1, 0, 1; alloc_ptr 0, 1, 2, 3.
- Drain 16 allocs → empty = 1, count = 0, alloc_gnt = 0 with requests held. Then free_ptr = 5 → count = 1 next cycle, next alloc returns 5, empty = 1 again.
- count = 1 with head = 9; assert a grant and free_ptr = 7 the same cycle → alloc_ptr = 9, count stays 1; next grant returns 7.
- rst pulsed while alloc_vld = 1 and count = 10 → alloc_vld = 0 and ready = 0 immediately; count = 16; INIT repeats; first post-ready alloc returns 0.
